riscv_branch_redirect_ctrl: RTL and testbench

//   Sequences branch resolution in the RV32 EX stage. Accepts one conditional branch
//   per handshake and evaluates the RV32 branch condition on rs1/rs2/funct3. Compares
//   the outcome and target against the front-end prediction.
//   On a mispredict it issues a one-cycle redirect and flush, then holds a fixed

---
 rtl/riscv_branch_redirect_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_riscv_branch_redirect_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_branch_redirect_ctrl.sv
// RV32 EX-stage branch resolution: evaluates the branch condition and checks it against the prediction.
// On a mispredict it issues a redirect/flush followed by a refill stall. Optional counters: `BRANCH_STATS_EN.
module riscv_branch_redirect_ctrl #(
    parameter int XLEN           = 32,
    parameter int REDIRECT_STALL = 2,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [XLEN-1:0]   br_pc,
    input  logic [XLEN-1:0]   br_imm,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [2:0]        funct3,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    output logic              resolve_valid,
    output logic              resolve_taken,
    output logic [XLEN-1:0]   resolve_pc,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              flush,
    output logic              stall,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispred
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REDIR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int         SC_W       = (REDIRECT_STALL > 1) ? $clog2(REDIRECT_STALL) : 1;
    localparam logic [SC_W-1:0] STALL_LOAD = (REDIRECT_STALL > 0) ? SC_W'(REDIRECT_STALL - 1) : '0;
    localparam bit         HAS_STALL  = (REDIRECT_STALL > 0);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SC_W-1:0]   r_stall_cnt;

    logic              r_br_ready;
    logic              r_resolve_valid;
    logic              r_resolve_taken;
    logic [XLEN-1:0]   r_resolve_pc;
    logic              r_redirect_valid;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              r_stall;

    logic              w_accept;
    logic              w_taken;
    logic              w_mispred;
    logic [XLEN-1:0]   w_tgt;
    logic [XLEN-1:0]   w_seq;

    // Signed less-than built from the unsigned compare: differing signs decide by rs1's sign.
    function automatic logic f_lt_signed(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (a[XLEN-1] != b[XLEN-1])
            return a[XLEN-1];
        return (a < b);
    endfunction

    function automatic logic f_branch_cond(input logic [2:0]      f3,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
        logic res;
        res = 1'b0;
        case (f3)
            3'd0:    res = (a == b);
            3'd1:    res = (a != b);
            3'd4:    res = f_lt_signed(a, b);
            3'd5:    res = !f_lt_signed(a, b);
            3'd6:    res = (a < b);
            3'd7:    res = !(a < b);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign w_accept  = br_valid && r_br_ready;
    assign w_taken   = f_branch_cond(funct3, rs1_data, rs2_data);
    assign w_tgt     = br_pc + br_imm;
    assign w_seq     = br_pc + XLEN'(4);
    assign w_mispred = (w_taken != pred_taken) ||
                       (w_taken && pred_taken && (pred_target != w_tgt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_mispred) w_state_nxt = ST_REDIR;
            ST_REDIR: w_state_nxt = HAS_STALL ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (r_stall_cnt == '0) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter is loaded while in REDIR so it holds REDIRECT_STALL-1 on the first DRAIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_state == ST_REDIR)
            r_stall_cnt <= STALL_LOAD;
        else if ((r_state == ST_DRAIN) && (r_stall_cnt != '0))
            r_stall_cnt <= r_stall_cnt - SC_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_br_ready       <= 1'b1;
            r_redirect_valid <= 1'b0;
            r_stall          <= 1'b0;
        end else begin
            r_br_ready       <= (w_state_nxt == ST_IDLE);
            r_redirect_valid <= (w_state_nxt == ST_REDIR);
            r_stall          <= (w_state_nxt == ST_DRAIN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resolve_valid <= 1'b0;
            r_resolve_taken <= 1'b0;
            r_resolve_pc    <= '0;
            r_redirect_pc   <= '0;
        end else begin
            r_resolve_valid <= w_accept;
            if (w_accept) begin
                r_resolve_taken <= w_taken;
                r_resolve_pc    <= br_pc;
                if (w_mispred)
                    r_redirect_pc <= w_taken ? w_tgt : w_seq;
            end
        end
    end

    assign br_ready       = r_br_ready;
    assign resolve_valid  = r_resolve_valid;
    assign resolve_taken  = r_resolve_taken;
    assign resolve_pc     = r_resolve_pc;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush          = r_redirect_valid;
    assign stall          = r_stall;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_mispred;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else if (w_accept) begin
            r_stat_branches <= f_sat_inc(r_stat_branches);
            if (w_mispred)
                r_stat_mispred <= f_sat_inc(r_stat_mispred);
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_mispred  = r_stat_mispred;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_riscv_branch_redirect_ctrl.sv
// Directed bench for riscv_branch_redirect_ctrl: scoreboard queue of resolved branches plus
// a second instance (no stall, 2-bit counters) for the zero-stall and saturation cases.
module tb_riscv_branch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic        br_valid2 = 1'b0;
    logic [31:0] br_pc = '0, br_imm = '0, rs1_data = '0, rs2_data = '0, pred_target = '0;
    logic [2:0]  funct3 = '0;
    logic        pred_taken = 1'b0;

    logic        br_ready, resolve_valid, resolve_taken, redirect_valid, flush, stall;
    logic [31:0] resolve_pc, redirect_pc;
    logic [15:0] stat_branches, stat_mispred;

    logic        br_ready2, resolve_valid2, resolve_taken2, redirect_valid2, flush2, stall2;
    logic [31:0] resolve_pc2, redirect_pc2;
    logic [1:0]  stat_branches2, stat_mispred2;

    int total = 0;
    int bad   = 0;
    int exp_br = 0;
    int exp_mis = 0;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic        mis;
        logic [31:0] rpc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    riscv_branch_redirect_ctrl #(.XLEN(32), .REDIRECT_STALL(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .br_pc(br_pc), .br_imm(br_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .funct3(funct3), .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_pc(resolve_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .stall(stall), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    riscv_branch_redirect_ctrl #(.XLEN(32), .REDIRECT_STALL(0), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .br_valid(br_valid2), .br_ready(br_ready2),
        .br_pc(br_pc), .br_imm(br_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .funct3(funct3), .pred_taken(pred_taken), .pred_target(pred_target),
        .resolve_valid(resolve_valid2), .resolve_taken(resolve_taken2), .resolve_pc(resolve_pc2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .flush(flush2),
        .stall(stall2), .stat_branches(stat_branches2), .stat_mispred(stat_mispred2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] stat_exp(input int n);
`ifdef BRANCH_STATS_EN
        return 32'(n);
`else
        return 32'(n & 0);
`endif
    endfunction

    // Present a branch to the main DUT (which must be ready) and record what it should resolve to.
    task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt);
        exp_t e;
        funct3 = f3; rs1_data = a; rs2_data = b; br_pc = pc; br_imm = imm;
        pred_taken = pt; pred_target = ptgt; br_valid = 1'b1;
        e.taken = model_taken(f3, a, b);
        e.pc    = pc;
        e.mis   = (e.taken != pt) || (e.taken && pt && (ptgt != pc + imm));
        e.rpc   = e.taken ? pc + imm : pc + 32'd4;
        q.push_back(e);
        exp_br++;
        if (e.mis) exp_mis++;
    endtask

    // One clock; compare against the scoreboard head if a resolution is due.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        br_valid = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("resolve_valid", 32'(resolve_valid), 32'd1);
            chk("resolve_taken", 32'(resolve_taken), 32'(e.taken));
            chk("resolve_pc", resolve_pc, e.pc);
            chk("redirect_valid", 32'(redirect_valid), 32'(e.mis));
            chk("flush", 32'(flush), 32'(e.mis));
            chk("br_ready", 32'(br_ready), 32'(!e.mis));
            if (e.mis) chk("redirect_pc", redirect_pc, e.rpc);
        end else begin
            chk("resolve_valid_idle", 32'(resolve_valid), 32'd0);
            chk("redirect_valid_idle", 32'(redirect_valid), 32'd0);
        end
        chk("stat_branches", 32'(stat_branches), stat_exp(exp_br));
        chk("stat_mispred", 32'(stat_mispred), stat_exp(exp_mis));
    endtask

    // After a REDIR cycle: two stall cycles then ready again.
    task automatic expect_drain();
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_on", 32'(stall), 32'd1);
            chk("ready_off", 32'(br_ready), 32'd0);
        end
        tick();
        chk("stall_off", 32'(stall), 32'd0);
        chk("ready_back", 32'(br_ready), 32'd1);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(br_ready), 32'd1);
        chk("rst_resolve_valid", 32'(resolve_valid), 32'd0);
        chk("rst_redirect", 32'(redirect_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resolve_pc", resolve_pc, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;
        tick();

        // correct taken BEQ
        drive(3'd0, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h120);
        tick();

        // BLT signed, mispredicted not-taken, with a wrong-path op offered during REDIR
        drive(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0, 32'h0);
        tick();
        br_valid = 1'b1;
        expect_drain();

        // BGEU not taken but predicted taken
        drive(3'd7, 32'd1, 32'hFFFF_FFFF, 32'h300, 32'h40, 1'b1, 32'h340);
        tick();
        expect_drain();

        // taken BNE with wrong target and wrapping target
        drive(3'd1, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b1, 32'h100);
        tick();
        expect_drain();

        // back-to-back correct predictions, including funct3=2 (never taken)
        drive(3'd6, 32'd3, 32'd9, 32'h500, 32'h10, 1'b1, 32'h510);
        tick();
        drive(3'd2, 32'd3, 32'd3, 32'h504, 32'h10, 1'b0, 32'h0);
        tick();
        drive(3'd5, 32'h8000_0000, 32'd0, 32'h508, 32'h10, 1'b0, 32'h0);
        tick();
        tick();

        // reset in DRAIN
        drive(3'd0, 32'd7, 32'd7, 32'h400, 32'h10, 1'b0, 32'h0);
        tick();
        tick();
        chk("pre_rst_stall", 32'(stall), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(br_ready), 32'd1);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_resolve_pc", resolve_pc, 32'd0);
        chk("mid_rst_stat_br", 32'(stat_branches), 32'd0);
        chk("mid_rst_stat_mis", 32'(stat_mispred), 32'd0);
        exp_br = 0;
        exp_mis = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_ready", 32'(br_ready), 32'd1);

        // stats: three correct then one mispredict
        drive(3'd0, 32'd1, 32'd1, 32'h600, 32'h8, 1'b1, 32'h608);
        tick();
        drive(3'd1, 32'd1, 32'd1, 32'h604, 32'h8, 1'b0, 32'h0);
        tick();
        drive(3'd6, 32'd0, 32'd1, 32'h608, 32'h8, 1'b1, 32'h610);
        tick();
        drive(3'd5, 32'hFFFF_FFFD, 32'd2, 32'h60C, 32'h8, 1'b1, 32'h614);
        tick();
        expect_drain();
        chk("stat_br_final", 32'(stat_branches), stat_exp(4));
        chk("stat_mis_final", 32'(stat_mispred), stat_exp(1));

        // zero-stall instance: five mispredicts, counters saturate at 3
        for (int i = 0; i < 5; i++) begin
            funct3 = 3'd0; rs1_data = 32'd1; rs2_data = 32'd1;
            br_pc = 32'h700 + 32'(i * 4); br_imm = 32'h100; pred_taken = 1'b0; pred_target = '0;
            br_valid2 = 1'b1;
            @(posedge clk);
            #1 br_valid2 = 1'b0;
            chk("d2_resolve", 32'(resolve_valid2), 32'd1);
            chk("d2_redirect", 32'(redirect_valid2), 32'd1);
            chk("d2_redirect_pc", redirect_pc2, 32'h800 + 32'(i * 4));
            chk("d2_ready_redir", 32'(br_ready2), 32'd0);
            @(posedge clk);
            #1;
            chk("d2_ready_back", 32'(br_ready2), 32'd1);
            chk("d2_no_stall", 32'(stall2), 32'd0);
            chk("d2_stat_mis", 32'(stat_mispred2), stat_exp((i + 1 > 3) ? 3 : i + 1));
            chk("d2_stat_br", 32'(stat_branches2), stat_exp((i + 1 > 3) ? 3 : i + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
